z16_prog_loader: RTL

Z16_PROG_LOADER -- requirements
Module: z16_prog_loader

---
 rtl/z16_pkg.sv | 31 +++
 rtl/z16_prog_loader_if.sv | 25 ++
 rtl/z16_prog_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/z16_pkg.sv
// Shared types for the z16 program loader: FSM state encodings and byte/word widths.
// Z16_LOADER_CHECKSUM_EN adds the CHK state.
package z16_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 16;

  localparam logic [STATE_W-1:0] ST_LEN_LO  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LEN_HI  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA_LO = 3'd2;
  localparam logic [STATE_W-1:0] ST_DATA_HI = 3'd3;
`ifdef Z16_LOADER_CHECKSUM_EN
  localparam logic [STATE_W-1:0] ST_CHK     = 3'd4;
`endif
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;
  localparam logic [STATE_W-1:0] ST_ERROR   = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    LEN_LO  = ST_LEN_LO,
    LEN_HI  = ST_LEN_HI,
    DATA_LO = ST_DATA_LO,
    DATA_HI = ST_DATA_HI,
`ifdef Z16_LOADER_CHECKSUM_EN
    CHK     = ST_CHK,
`endif
    DONE    = ST_DONE,
    ERROR   = ST_ERROR
  } state_e;

endpackage

// File: rtl/z16_prog_loader_if.sv
// Bundle of the loader's byte-stream, instruction-memory and status signals.
interface z16_prog_loader_if;
  logic        reload;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_wen;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  // Host / byte source side.
  modport master (
    output reload, rx_valid, rx_data,
    input  rx_ready, imem_wen, imem_addr, imem_wdata, cpu_rst, done, error
  );

  // Loader side.
  modport slave (
    input  reload, rx_valid, rx_data,
    output rx_ready, imem_wen, imem_addr, imem_wdata, cpu_rst, done, error
  );
endinterface

// File: rtl/z16_prog_loader.sv
// Byte-stream program loader: length-prefixed little-endian words into instruction memory.
// Optional trailing 8-bit checksum when Z16_LOADER_CHECKSUM_EN is defined.
module z16_prog_loader
  import z16_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reload,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_imem_wen,
  output logic [15:0] o_imem_addr,
  output logic [15:0] o_imem_wdata,
  output logic        o_cpu_rst,
  output logic        o_done,
  output logic        o_error
);

`ifdef Z16_LOADER_CHECKSUM_EN
  localparam state_e END_ST = CHK;
`else
  localparam state_e END_ST = DONE;
`endif

  state_e              state_q,    state_d;
  logic [BYTE_W-1:0]   len_lo_q,   len_lo_d;
  logic [WORD_W-1:0]   len_q,      len_d;
  logic [BYTE_W-1:0]   data_lo_q,  data_lo_d;
  logic [WORD_W-1:0]   cnt_q,      cnt_d;
  logic                wen_q,      wen_d;
  logic [WORD_W-1:0]   addr_q,     addr_d;
  logic [WORD_W-1:0]   wdata_q,    wdata_d;
  logic                rx_ready_q, rx_ready_d;
  logic                cpu_rst_q,  cpu_rst_d;
  logic                done_q,     done_d;
  logic                error_q,    error_d;
`ifdef Z16_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   sum_q,      sum_d;
`endif

  logic                accept;
  logic [WORD_W-1:0]   n_w;

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= LEN_LO;
      len_lo_q   <= '0;
      len_q      <= '0;
      data_lo_q  <= '0;
      cnt_q      <= '0;
      wen_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      rx_ready_q <= 1'b1;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef Z16_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      data_lo_q  <= data_lo_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef Z16_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state, byte-pair assembly and registered-output decode.
  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    data_lo_d = data_lo_q;
    cnt_d     = cnt_q;
    wen_d     = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef Z16_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    accept    = i_rx_valid && rx_ready_q;
    n_w       = {i_rx_data, len_lo_q};

    if (i_reload) begin
      // Reload beats a simultaneous byte: nothing from this cycle is kept.
      state_d = LEN_LO;
      cnt_d   = '0;
`ifdef Z16_LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else if (accept) begin
`ifdef Z16_LOADER_CHECKSUM_EN
      sum_d = 8'(sum_q + i_rx_data);
`endif
      case (state_q)
        LEN_LO: begin
          len_lo_d = i_rx_data;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          len_d = n_w;
          if (32'(n_w) > MAX_WORDS)  state_d = ERROR;
          else if (n_w == '0)         state_d = END_ST;
          else                        state_d = DATA_LO;
        end
        DATA_LO: begin
          data_lo_d = i_rx_data;
          state_d   = DATA_HI;
        end
        DATA_HI: begin
          wen_d   = 1'b1;
          wdata_d = {i_rx_data, data_lo_q};
          addr_d  = BASE_ADDR + {cnt_q[14:0], 1'b0};
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_q == (len_q - 16'd1)) ? END_ST : DATA_LO;
        end
`ifdef Z16_LOADER_CHECKSUM_EN
        CHK: begin
          state_d = (8'(sum_q + i_rx_data) == 8'd0) ? DONE : ERROR;
        end
`endif
        default: ;
      endcase
    end

    rx_ready_d = (state_d != DONE) && (state_d != ERROR);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
    // Hold the CPU in reset through the cycle carrying the final write strobe.
    cpu_rst_d  = (state_d != DONE) || wen_d;
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_imem_wen   = wen_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule
